// File: rtl/weight_load_ctrl.sv
// Sequencer that fills a weight FIFO from weight memory, holds it, then drains
// it into the array by shifting zeros in behind the weights.
module weight_load_ctrl #(
    parameter int FIFO_STAGES = 4,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  drain,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  fifo_en,
    output logic                  fifo_zero_in,
    output logic                  busy,
    output logic                  loaded,
    output logic                  done,
    output logic [1:0]            fsm_state
);

    localparam int CNT_W = $clog2(FIFO_STAGES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FIFO_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // start and drain are single-cycle requests with no ready: start is taken
    // only in IDLE, drain only in FULL; any other request is dropped, not queued.
    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  rd_n, fen_n, zero_n, loaded_n, done_n;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_n   = mem_addr;
        rd_n     = 1'b0;
        fen_n    = 1'b0;
        zero_n   = 1'b0;
        loaded_n = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FILL;
                    cnt_n   = '0;
                    addr_n  = base_addr;
                    rd_n    = 1'b1;
                end
            end
            FILL: begin
                // Memory data lands one cycle after each read, so the FIFO
                // shift trails the read strobe by exactly one cycle.
                fen_n = mem_rd_en;
                if (mem_rd_en) begin
                    if (cnt != LAST) begin
                        rd_n   = 1'b1;
                        cnt_n  = cnt + 1'b1;
                        addr_n = mem_addr + 1'b1;
                    end
                end else begin
                    state_n  = FULL;
                    loaded_n = 1'b1;
                    cnt_n    = '0;
                end
            end
            FULL: begin
                if (drain) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                    fen_n   = 1'b1;
                    zero_n  = 1'b1;
                end else begin
                    loaded_n = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n  = cnt + 1'b1;
                    fen_n  = 1'b1;
                    zero_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            fifo_en      <= 1'b0;
            fifo_zero_in <= 1'b0;
            busy         <= 1'b0;
            loaded       <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            mem_rd_en    <= rd_n;
            mem_addr     <= addr_n;
            fifo_en      <= fen_n;
            fifo_zero_in <= zero_n;
            busy         <= (state_n != IDLE);
            loaded       <= loaded_n;
            done         <= done_n;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Randomized bench for weight_load_ctrl, checked against a cycle-offset
// model: every output is a function of the phase and cycles since acceptance.
module tb_weight_load_ctrl;

    localparam int N  = 4;
    localparam int AW = 8;

    localparam int P_IDLE  = 0;
    localparam int P_FILL  = 1;
    localparam int P_FULL  = 2;
    localparam int P_DRAIN = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          drain = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic          fifo_en;
    logic          fifo_zero_in;
    logic          busy;
    logic          loaded;
    logic          done;
    logic [1:0]    fsm_state;

    int checks = 0;
    int errors = 0;

    int m_ph = P_IDLE;
    int m_t = 0;
    int m_base = 0;
    int cyc = 0;
    int done_obs = 0;
    int done_exp = 0;

    weight_load_ctrl #(.FIFO_STAGES(N), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .drain(drain),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .fifo_en(fifo_en),
        .fifo_zero_in(fifo_zero_in),
        .busy(busy),
        .loaded(loaded),
        .done(done),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd"},     32'(mem_rd_en),    0);
        check({tag, "_addr"},   32'(mem_addr),     0);
        check({tag, "_fen"},    32'(fifo_en),      0);
        check({tag, "_zero"},   32'(fifo_zero_in), 0);
        check({tag, "_busy"},   32'(busy),         0);
        check({tag, "_loaded"}, 32'(loaded),       0);
        check({tag, "_done"},   32'(done),         0);
        check({tag, "_state"},  32'(fsm_state),    0);
    endtask

    // Drive one cycle of requests, advance the model, then compare.
    task automatic step(input logic s, input logic d, input logic [AW-1:0] b);
        int k;
        int e_done;
        int e_rd;
        int e_fen;
        int e_zero;
        start = s;
        drain = d;
        base_addr = b;
        if (m_ph == P_IDLE && s) begin
            m_ph = P_FILL;
            m_t = cyc;
            m_base = int'(b);
        end else if (m_ph == P_FULL && d) begin
            m_ph = P_DRAIN;
            m_t = cyc;
        end
        k = cyc + 1 - m_t;
        e_done = 0;
        if (m_ph == P_FILL && k == N + 2) m_ph = P_FULL;
        if (m_ph == P_DRAIN && k == N + 1) begin
            m_ph = P_IDLE;
            e_done = 1;
        end
        e_rd   = (m_ph == P_FILL && k >= 1 && k <= N) ? 1 : 0;
        e_zero = (m_ph == P_DRAIN && k >= 1 && k <= N) ? 1 : 0;
        e_fen  = ((m_ph == P_FILL && k >= 2 && k <= N + 1) || e_zero == 1) ? 1 : 0;
        cyc++;
        @(posedge clk);
        #1;
        check("mem_rd_en",    32'(mem_rd_en),    32'(e_rd));
        if (e_rd == 1) check("mem_addr", 32'(mem_addr), 32'((m_base + k - 1) & ((1 << AW) - 1)));
        check("fifo_en",      32'(fifo_en),      32'(e_fen));
        check("fifo_zero_in", 32'(fifo_zero_in), 32'(e_zero));
        check("busy",         32'(busy),         32'(m_ph != P_IDLE));
        check("loaded",       32'(loaded),       32'(m_ph == P_FULL));
        check("done",         32'(done),         32'(e_done));
        check("state",        32'(fsm_state),    32'(m_ph));
        done_obs += int'(done);
        done_exp += e_done;
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released
    // so the very next edge sees reset=1.
    task automatic async_reset();
        #3;
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        m_ph = P_IDLE;
        @(posedge clk);
        #1;
        check_zero("held_rst");
        reset = 1'b1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, AW'($urandom));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;

        // Plain fill from 0x10, drain ten cycles after start, then a
        // back-to-back start in the done cycle with a wrapping base address.
        step(1'b1, 1'b0, 8'h10);
        idle_steps(9);
        step(1'b0, 1'b1, 8'h00);
        idle_steps(4);
        step(1'b1, 1'b0, 8'hFE);
        idle_steps(7);

        // start and drain together in FULL: drain must win.
        step(1'b1, 1'b1, 8'h55);
        idle_steps(6);

        // Requests that must be ignored: drain in IDLE, start/drain in FILL.
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b1, 8'h30);
        step(1'b0, 1'b1, 8'h31);
        idle_steps(5);
        step(1'b0, 1'b1, 8'h00);
        idle_steps(6);

        // Reset mid-fill, then a full fill from a new base right after release.
        step(1'b1, 1'b0, 8'h40);
        idle_steps(2);
        async_reset();
        step(1'b1, 1'b0, 8'h80);
        idle_steps(8);
        step(1'b0, 1'b1, 8'h00);
        idle_steps(2);
        async_reset();
        idle_steps(3);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, AW'($urandom));
            end
        end
        idle_steps(12);

        check("done_count", 32'(done_obs), 32'(done_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
